// File: rtl/vlsu_txn_tracker_if.sv
// AR/AW pass-through and R/B snoop bundle for the VLSU transaction tracker.
// Signal suffixes are relative to the tracker: _i enters it, _o leaves it.
`default_nettype none

interface vlsu_txn_tracker_if #(
  parameter int unsigned AxiAddrWidth = 64
) ();
  logic                    ar_valid_i;
  logic                    ar_ready_o;
  logic [AxiAddrWidth-1:0] ar_addr_i;
  logic [7:0]              ar_len_i;
  logic [2:0]              ar_size_i;
  logic                    ar_valid_o;
  logic                    ar_ready_i;

  logic                    aw_valid_i;
  logic                    aw_ready_o;
  logic [AxiAddrWidth-1:0] aw_addr_i;
  logic [7:0]              aw_len_i;
  logic [2:0]              aw_size_i;
  logic                    aw_valid_o;
  logic                    aw_ready_i;

  logic                    r_valid_i;
  logic                    r_ready_i;
  logic                    r_last_i;
  logic                    b_valid_i;
  logic                    b_ready_i;

  modport slave (
    input  ar_valid_i, ar_addr_i, ar_len_i, ar_size_i, ar_ready_i,
    output ar_ready_o, ar_valid_o,
    input  aw_valid_i, aw_addr_i, aw_len_i, aw_size_i, aw_ready_i,
    output aw_ready_o, aw_valid_o,
    input  r_valid_i, r_ready_i, r_last_i, b_valid_i, b_ready_i
  );

  modport master (
    output ar_valid_i, ar_addr_i, ar_len_i, ar_size_i, ar_ready_i,
    input  ar_ready_o, ar_valid_o,
    output aw_valid_i, aw_addr_i, aw_len_i, aw_size_i, aw_ready_i,
    input  aw_ready_o, aw_valid_o,
    output r_valid_i, r_ready_i, r_last_i, b_valid_i, b_ready_i
  );
endinterface

`default_nettype wire

// File: rtl/vlsu_txn_tracker.sv
// vlsu_txn_tracker: caps outstanding AXI read/write bursts and stalls reads
// overlapping pending write byte ranges. Rev 1.0
`default_nettype none

module vlsu_txn_tracker #(
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned MaxRdTxns    = 8,
  parameter int unsigned MaxWrTxns    = 4,
  parameter bit          HazardCheck  = 1'b1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             core_st_pending_i,
  vlsu_txn_tracker_if.slave                bus,
  output logic                             load_complete_o,
  output logic                             store_complete_o,
  output logic                             store_pending_o,
  output logic [$clog2(MaxRdTxns+1)-1:0]   rd_cnt_o,
  output logic                             protocol_err_o
);

  localparam int unsigned RdCntW = $clog2(MaxRdTxns + 1);
  localparam int unsigned WrCntW = $clog2(MaxWrTxns + 1);
  localparam int unsigned PtrW   = (MaxWrTxns > 1) ? $clog2(MaxWrTxns) : 1;
  localparam int unsigned RngW   = AxiAddrWidth + 1;

  typedef logic [RngW-1:0] rng_t;

  // One extra bit keeps the inclusive end address from wrapping at the top of memory.
  function automatic rng_t range_end(input logic [AxiAddrWidth-1:0] addr,
                                     input logic [7:0] len,
                                     input logic [2:0] size);
    rng_t bytes;
    bytes = (rng_t'(len) + rng_t'(1)) << size;
    return rng_t'(addr) + bytes - rng_t'(1);
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxWrTxns - 1)) ? '0 : p + PtrW'(1);
  endfunction

  rng_t                wr_start_q [MaxWrTxns];
  rng_t                wr_end_q   [MaxWrTxns];
  logic [MaxWrTxns-1:0] wr_vld_q;
  logic [PtrW-1:0]     head_q, tail_q;
  logic [WrCntW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [RdCntW-1:0]   rd_cnt_q, rd_cnt_d;
  logic                load_cmp_q, store_cmp_q, store_pend_q, perr_q;

  rng_t ar_start, ar_end, aw_start, aw_end;
  logic overlap, aw_ok, ar_ok, aw_hs, ar_hs;
  logic r_last_hs, b_hs, r_retire, b_pop, perr_set;

  assign ar_start = rng_t'(bus.ar_addr_i);
  assign ar_end   = range_end(bus.ar_addr_i, bus.ar_len_i, bus.ar_size_i);
  assign aw_start = rng_t'(bus.aw_addr_i);
  assign aw_end   = range_end(bus.aw_addr_i, bus.aw_len_i, bus.aw_size_i);

  always_comb begin
    overlap = 1'b0;
    for (int i = 0; i < int'(MaxWrTxns); i++) begin
      if (wr_vld_q[i] && (ar_start <= wr_end_q[i]) && (wr_start_q[i] <= ar_end)) begin
        overlap = 1'b1;
      end
    end
  end

  // A same-cycle AW blocks AR so a new table entry can never retroactively
  // invalidate an AR that has already been presented downstream.
  assign aw_ok = (wr_cnt_q < WrCntW'(MaxWrTxns));
  assign aw_hs = bus.aw_valid_i & bus.aw_ready_i & aw_ok;
  assign ar_ok = (rd_cnt_q < RdCntW'(MaxRdTxns)) &
                 (~HazardCheck | (~core_st_pending_i & ~aw_hs & ~overlap));
  assign ar_hs = bus.ar_valid_i & bus.ar_ready_i & ar_ok;

  assign bus.ar_valid_o = bus.ar_valid_i & ar_ok;
  assign bus.ar_ready_o = bus.ar_ready_i & ar_ok;
  assign bus.aw_valid_o = bus.aw_valid_i & aw_ok;
  assign bus.aw_ready_o = bus.aw_ready_i & aw_ok;

  assign r_last_hs = bus.r_valid_i & bus.r_ready_i & bus.r_last_i;
  assign b_hs      = bus.b_valid_i & bus.b_ready_i;
  assign r_retire  = r_last_hs & (rd_cnt_q != '0);
  assign b_pop     = b_hs & (wr_cnt_q != '0);
  assign perr_set  = (r_last_hs & (rd_cnt_q == '0)) | (b_hs & (wr_cnt_q == '0));

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    case ({aw_hs, b_pop})
      2'b10:   wr_cnt_d = wr_cnt_q + WrCntW'(1);
      2'b01:   wr_cnt_d = wr_cnt_q - WrCntW'(1);
      default: wr_cnt_d = wr_cnt_q;
    endcase
    rd_cnt_d = rd_cnt_q;
    case ({ar_hs, r_retire})
      2'b10:   rd_cnt_d = rd_cnt_q + RdCntW'(1);
      2'b01:   rd_cnt_d = rd_cnt_q - RdCntW'(1);
      default: rd_cnt_d = rd_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_vld_q     <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      load_cmp_q   <= 1'b0;
      store_cmp_q  <= 1'b0;
      store_pend_q <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      // Push and pop never target the same slot: push needs a free slot, pop a full one.
      if (aw_hs) begin
        wr_vld_q[tail_q] <= 1'b1;
        tail_q           <= ptr_inc(tail_q);
      end
      if (b_pop) begin
        wr_vld_q[head_q] <= 1'b0;
        head_q           <= ptr_inc(head_q);
      end
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      load_cmp_q   <= r_retire;
      store_cmp_q  <= b_pop;
      store_pend_q <= (wr_cnt_d != '0);
      if (perr_set) begin
        perr_q <= 1'b1;
      end
    end
  end

  // Range payload is qualified by wr_vld_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (aw_hs) begin
      wr_start_q[tail_q] <= aw_start;
      wr_end_q[tail_q]   <= aw_end;
    end
  end

  assign load_complete_o  = load_cmp_q;
  assign store_complete_o = store_cmp_q;
  assign store_pending_o  = store_pend_q;
  assign rd_cnt_o         = rd_cnt_q;
  assign protocol_err_o   = perr_q;

endmodule

`default_nettype wire

// File: tb/tb_vlsu_txn_tracker.sv
// Self-checking bench for vlsu_txn_tracker: vector table plus scoreboard of
// registered outputs, and hand-written reset / no-hazard-check sequences.
`default_nettype none

module tb_vlsu_txn_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic core_st  = 1'b0;
  logic core_st2 = 1'b0;
  always #5 clk = ~clk;

  vlsu_txn_tracker_if #(.AxiAddrWidth(64)) bus  ();
  vlsu_txn_tracker_if #(.AxiAddrWidth(64)) bus2 ();

  logic       lc, sc, sp, pe, lc2, sc2, sp2, pe2;
  logic [3:0] rc, rc2;

  vlsu_txn_tracker #(.AxiAddrWidth(64), .MaxRdTxns(8), .MaxWrTxns(4), .HazardCheck(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst), .core_st_pending_i(core_st), .bus(bus),
    .load_complete_o(lc), .store_complete_o(sc), .store_pending_o(sp),
    .rd_cnt_o(rc), .protocol_err_o(pe)
  );

  vlsu_txn_tracker #(.AxiAddrWidth(64), .MaxRdTxns(8), .MaxWrTxns(4), .HazardCheck(1'b0)) u_nohz (
    .clk_i(clk), .rst_i(rst), .core_st_pending_i(core_st2), .bus(bus2),
    .load_complete_o(lc2), .store_complete_o(sc2), .store_pending_o(sp2),
    .rd_cnt_o(rc2), .protocol_err_o(pe2)
  );

  typedef struct {
    bit cst; bit arv; int unsigned ara; bit [7:0] arl; bit [2:0] ars;
    bit awv; int unsigned awa; bit [7:0] awl; bit [2:0] aws;
    bit rl; bit bv; bit arok; bit awok;
    bit [3:0] rc; bit lc; bit sc; bit sp; bit pe;
  } vec_t;

  typedef struct { int idx; bit [3:0] rc; bit lc; bit sc; bit sp; bit pe; } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   cur   = 0;

  function automatic vec_t mv(bit cst, bit arv, int unsigned ara, bit [7:0] arl, bit [2:0] ars,
                              bit awv, int unsigned awa, bit [7:0] awl, bit [2:0] aws,
                              bit rl, bit bv, bit arok, bit awok,
                              bit [3:0] erc, bit elc, bit esc, bit esp, bit epe);
    vec_t v;
    v = '{cst, arv, ara, arl, ars, awv, awa, awl, aws, rl, bv, arok, awok, erc, elc, esc, esp, epe};
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec %0d %s: got %0h, expected %0h", cur, name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    core_st = 1'b0;
    bus.ar_valid_i = 1'b0; bus.ar_addr_i = '0; bus.ar_len_i = '0; bus.ar_size_i = '0;
    bus.aw_valid_i = 1'b0; bus.aw_addr_i = '0; bus.aw_len_i = '0; bus.aw_size_i = '0;
    bus.ar_ready_i = 1'b1; bus.aw_ready_i = 1'b1;
    bus.r_valid_i = 1'b0; bus.r_ready_i = 1'b0; bus.r_last_i = 1'b0;
    bus.b_valid_i = 1'b0; bus.b_ready_i = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    core_st = v.cst;
    bus.ar_valid_i = v.arv; bus.ar_addr_i = 64'(v.ara); bus.ar_len_i = v.arl; bus.ar_size_i = v.ars;
    bus.aw_valid_i = v.awv; bus.aw_addr_i = 64'(v.awa); bus.aw_len_i = v.awl; bus.aw_size_i = v.aws;
    bus.ar_ready_i = 1'b1; bus.aw_ready_i = 1'b1;
    bus.r_valid_i = v.rl; bus.r_ready_i = v.rl; bus.r_last_i = v.rl;
    bus.b_valid_i = v.bv; bus.b_ready_i = v.bv;
    #1;
    n_vec++;
    chk("ar_valid_o", bus.ar_valid_o, v.arv & v.arok);
    chk("ar_ready_o", bus.ar_ready_o, v.arok);
    chk("aw_valid_o", bus.aw_valid_o, v.awv & v.awok);
    chk("aw_ready_o", bus.aw_ready_o, v.awok);
    sb.push_back('{cur, v.rc, v.lc, v.sc, v.sp, v.pe});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("rd_cnt_o", rc, e.rc);
    chk("load_complete_o", lc, e.lc);
    chk("store_complete_o", sc, e.sc);
    chk("store_pending_o", sp, e.sp);
    chk("protocol_err_o", pe, e.pe);
    cur++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    bus2.ar_valid_i = 1'b0; bus2.ar_addr_i = '0; bus2.ar_len_i = '0; bus2.ar_size_i = '0;
    bus2.aw_valid_i = 1'b0; bus2.aw_addr_i = '0; bus2.aw_len_i = '0; bus2.aw_size_i = '0;
    bus2.ar_ready_i = 1'b1; bus2.aw_ready_i = 1'b1;
    bus2.r_valid_i = 1'b0; bus2.r_ready_i = 1'b0; bus2.r_last_i = 1'b0;
    bus2.b_valid_i = 1'b0; bus2.b_ready_i = 1'b0;

    //          cst arv ara     arl ars awv awa     awl aws rl bv arok awok rc lc sc sp pe
    tbl.push_back(mv(0, 0, 0,       0, 0,  0, 0,       0, 0,  0, 0, 1, 1,   0, 0, 0, 0, 0));
    tbl.push_back(mv(1, 1, 'h8000,  0, 0,  0, 0,       0, 0,  0, 0, 0, 1,   0, 0, 0, 0, 0));
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mv(0, 1, 'h8000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'(i), 0, 0, 0, 0));
    tbl.push_back(mv(0, 1, 'h8000,  0, 0,  0, 0,       0, 0,  0, 0, 0, 1,   8, 0, 0, 0, 0));
    tbl.push_back(mv(0, 1, 'h8000,  0, 0,  0, 0,       0, 0,  1, 0, 0, 1,   7, 1, 0, 0, 0));
    tbl.push_back(mv(0, 1, 'h8000,  0, 0,  0, 0,       0, 0,  0, 0, 1, 1,   8, 0, 0, 0, 0));
    for (int i = 7; i >= 0; i--)
      tbl.push_back(mv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, (i + 1 < 8), 1, 4'(i), 1, 0, 0, 0));
    // Read-after-write hazard against 0x1000..0x101F
    tbl.push_back(mv(0, 0, 0,       0, 0,  1, 'h1000,  3, 3,  0, 0, 0, 1,   0, 0, 0, 1, 0));
    tbl.push_back(mv(0, 1, 'h1018,  0, 3,  0, 0,       0, 0,  0, 0, 0, 1,   0, 0, 0, 1, 0));
    tbl.push_back(mv(0, 1, 'h1018,  0, 3,  0, 0,       0, 0,  0, 0, 0, 1,   0, 0, 0, 1, 0));
    tbl.push_back(mv(0, 1, 'h1018,  0, 3,  0, 0,       0, 0,  0, 1, 0, 1,   0, 0, 1, 0, 0));
    tbl.push_back(mv(0, 1, 'h1018,  0, 3,  0, 0,       0, 0,  0, 0, 1, 1,   1, 0, 0, 0, 0));
    tbl.push_back(mv(0, 0, 0,       0, 0,  1, 'h1000,  3, 3,  0, 0, 0, 1,   1, 0, 0, 1, 0));
    tbl.push_back(mv(0, 1, 'h1020,  0, 3,  0, 0,       0, 0,  0, 0, 1, 1,   2, 0, 0, 1, 0));
    tbl.push_back(mv(0, 1, 'h0FF8,  0, 3,  0, 0,       0, 0,  0, 0, 1, 1,   3, 0, 0, 1, 0));
    tbl.push_back(mv(0, 1, 'h0FF8,  1, 3,  0, 0,       0, 0,  0, 0, 0, 1,   3, 0, 0, 1, 0));
    tbl.push_back(mv(0, 1, 'h0FF8,  1, 3,  0, 0,       0, 0,  0, 1, 0, 1,   3, 0, 1, 0, 0));
    tbl.push_back(mv(0, 1, 'h0FF8,  1, 3,  0, 0,       0, 0,  0, 0, 1, 1,   4, 0, 0, 0, 0));
    // Simultaneous AR+AW: AW wins, AR next cycle
    tbl.push_back(mv(0, 1, 'h9000,  0, 0,  1, 'h2000,  0, 0,  0, 0, 0, 1,   4, 0, 0, 1, 0));
    tbl.push_back(mv(0, 1, 'h9000,  0, 0,  0, 0,       0, 0,  0, 0, 1, 1,   5, 0, 0, 1, 0));
    // Fill the write table, then a blocked AW alongside a B
    tbl.push_back(mv(0, 0, 0,       0, 0,  1, 'h3000,  0, 0,  0, 0, 0, 1,   5, 0, 0, 1, 0));
    tbl.push_back(mv(0, 0, 0,       0, 0,  1, 'h3100,  0, 0,  0, 0, 0, 1,   5, 0, 0, 1, 0));
    tbl.push_back(mv(0, 0, 0,       0, 0,  1, 'h3200,  0, 0,  0, 0, 0, 1,   5, 0, 0, 1, 0));
    tbl.push_back(mv(0, 0, 0,       0, 0,  1, 'h3300,  0, 0,  0, 1, 1, 0,   5, 0, 1, 1, 0));
    tbl.push_back(mv(0, 0, 0,       0, 0,  1, 'h3300,  0, 0,  0, 0, 0, 1,   5, 0, 0, 1, 0));
    tbl.push_back(mv(0, 0, 0,       0, 0,  0, 0,       0, 0,  0, 1, 1, 0,   5, 0, 1, 1, 0));
    tbl.push_back(mv(0, 0, 0,       0, 0,  0, 0,       0, 0,  0, 1, 1, 1,   5, 0, 1, 1, 0));
    tbl.push_back(mv(0, 0, 0,       0, 0,  0, 0,       0, 0,  0, 1, 1, 1,   5, 0, 1, 1, 0));
    tbl.push_back(mv(0, 0, 0,       0, 0,  0, 0,       0, 0,  0, 1, 1, 1,   5, 0, 1, 0, 0));
    // Core store pending gates AR, release issues same cycle
    tbl.push_back(mv(1, 1, 'h9000,  0, 0,  0, 0,       0, 0,  0, 0, 0, 1,   5, 0, 0, 0, 0));
    tbl.push_back(mv(0, 1, 'h9000,  0, 0,  0, 0,       0, 0,  0, 0, 1, 1,   6, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[k]) apply(tbl[k]);

    // Reset in the middle of two outstanding writes, then a stray B and R-last
    apply(mv(0, 0, 0, 0, 0, 1, 'h4000, 0, 0, 0, 0, 0, 1, 6, 0, 0, 1, 0));
    apply(mv(0, 0, 0, 0, 0, 1, 'h4100, 0, 0, 0, 0, 0, 1, 6, 0, 0, 1, 0));
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    chk("rst rd_cnt_o", rc, 0);
    chk("rst store_pending_o", sp, 0);
    chk("rst protocol_err_o", pe, 0);
    @(negedge clk);
    rst = 1'b0;
    apply(mv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1));
    apply(mv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1));
    apply(mv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));

    // Hazard checking disabled: AR and AW both pass, overlaps and core stores ignored
    @(negedge clk);
    core_st2 = 1'b1;
    bus2.ar_valid_i = 1'b1; bus2.ar_addr_i = 64'h2000;
    bus2.aw_valid_i = 1'b1; bus2.aw_addr_i = 64'h2000;
    #1;
    n_vec++;
    chk("nohz ar_valid_o", bus2.ar_valid_o, 1);
    chk("nohz aw_valid_o", bus2.aw_valid_o, 1);
    @(posedge clk);
    #1;
    chk("nohz rd_cnt_o", rc2, 1);
    chk("nohz store_pending_o", sp2, 1);
    @(negedge clk);
    bus2.aw_valid_i = 1'b0;
    #1;
    n_vec++;
    chk("nohz overlap ar_valid_o", bus2.ar_valid_o, 1);
    @(posedge clk);
    #1;
    chk("nohz rd_cnt_o 2", rc2, 2);
    chk("nohz protocol_err_o", pe2, 0);
    chk("nohz completes", {lc2, sc2}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
